// File: rtl/down_timer.sv
// down_timer: loadable down-counter with one-cycle terminal-count pulse and
// optional auto-reload, usable as a one-shot timeout or a periodic tick source.
module down_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] S,
  output logic             tc,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             tc_q, tc_d;

  // State, count, reload value and tc flops; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      r_q     <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
      tc_q    <= tc_d;
    end
  end

  // Next-state: load beats expiry beats decrement beats hold.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    r_d     = r_q;
    tc_d    = 1'b0;
    if (load) begin
      r_d     = D;
      s_d     = D;
      state_d = (D != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (s_q > ONE) begin
        s_d = s_q - ONE;
      end else if (s_q == ONE) begin
        // Expiry: auto_reload only matters on this edge.
        tc_d = 1'b1;
        if (auto_reload) begin
          s_d = r_q;
        end else begin
          s_d     = '0;
          state_d = IDLE;
        end
      end else begin
        // A zero count never decrements; fall back to stopped.
        state_d = IDLE;
      end
    end
  end

  assign S    = s_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);

endmodule
